// File: rtl/turn_controller.sv
// Chess-clock game sequencer: chooses which player's timer counts, handles
// start/pause/hand-over, and emits LOAD/INC pulses plus END/WINNER results.
module turn_controller #(
  parameter int MOVE_W = 8,
  parameter bit INC_EN = 1'b1
) (
  input  logic              CLK,
  input  logic              CLR,
  input  logic              CE,
  input  logic              START,
  input  logic              PAUSE,
  input  logic              BTN1,
  input  logic              BTN2,
  input  logic              OVERFLOW1,
  input  logic              OVERFLOW2,
  output logic              EN1,
  output logic              EN2,
  output logic              LOAD,
  output logic              INC1,
  output logic              INC2,
  output logic [2:0]        STATE,
  output logic [1:0]        WINNER,
  output logic              END,
  output logic [MOVE_W-1:0] MOVES
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_RUN1   = 3'd1,
    S_RUN2   = 3'd2,
    S_PAUSED = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  localparam logic [MOVE_W-1:0] MOVES_MAX = '1;

  state_t            r_state;
  logic              r_saved_p2;
  logic              r_load;
  logic              r_inc1;
  logic              r_inc2;
  logic              r_end;
  logic [1:0]        r_winner;
  logic [MOVE_W-1:0] r_moves;
  logic              r_start_prev;
  logic              r_pause_prev;
  logic              r_btn1_prev;
  logic              r_btn2_prev;

  logic w_start_edge;
  logic w_pause_edge;
  logic w_btn1_edge;
  logic w_btn2_edge;

  assign w_start_edge = START & ~r_start_prev;
  assign w_pause_edge = PAUSE & ~r_pause_prev;
  assign w_btn1_edge  = BTN1  & ~r_btn1_prev;
  assign w_btn2_edge  = BTN2  & ~r_btn2_prev;

  always_ff @(posedge CLK) begin
    if (CLR) begin
      r_state      <= S_IDLE;
      r_saved_p2   <= 1'b0;
      r_load       <= 1'b0;
      r_inc1       <= 1'b0;
      r_inc2       <= 1'b0;
      r_end        <= 1'b0;
      r_winner     <= 2'b00;
      r_moves      <= '0;
      // History forced high so a button held through reset yields no edge.
      r_start_prev <= 1'b1;
      r_pause_prev <= 1'b1;
      r_btn1_prev  <= 1'b1;
      r_btn2_prev  <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments throughout so every register samples
      // pre-edge values; the pulse defaults below are overridden later in
      // the same block and the last assignment wins.
      r_start_prev <= START;
      r_pause_prev <= PAUSE;
      r_btn1_prev  <= BTN1;
      r_btn2_prev  <= BTN2;
      r_load       <= 1'b0;
      r_inc1       <= 1'b0;
      r_inc2       <= 1'b0;

      case (r_state)
        S_IDLE: begin
          if (w_start_edge) begin
            r_state <= S_RUN1;
            r_load  <= 1'b1;
          end
        end
        S_RUN1: begin
          if (OVERFLOW1) begin
            r_state  <= S_DONE;
            r_winner <= 2'b10;
            r_end    <= 1'b1;
          end else if (w_pause_edge) begin
            r_state    <= S_PAUSED;
            r_saved_p2 <= 1'b0;
          end else if (w_btn1_edge) begin
            r_state <= S_RUN2;
            r_inc1  <= INC_EN;
            if (r_moves != MOVES_MAX) r_moves <= r_moves + 1'b1;
          end
        end
        S_RUN2: begin
          if (OVERFLOW2) begin
            r_state  <= S_DONE;
            r_winner <= 2'b01;
            r_end    <= 1'b1;
          end else if (w_pause_edge) begin
            r_state    <= S_PAUSED;
            r_saved_p2 <= 1'b1;
          end else if (w_btn2_edge) begin
            r_state <= S_RUN1;
            r_inc2  <= INC_EN;
            if (r_moves != MOVES_MAX) r_moves <= r_moves + 1'b1;
          end
        end
        S_PAUSED: begin
          if (w_pause_edge || w_start_edge)
            r_state <= r_saved_p2 ? S_RUN2 : S_RUN1;
        end
        S_DONE: begin
          r_state <= S_DONE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Enables are gated straight from CE so the timers see the tick in-cycle.
  assign EN1    = CE & (r_state == S_RUN1);
  assign EN2    = CE & (r_state == S_RUN2);
  assign LOAD   = r_load;
  assign INC1   = r_inc1;
  assign INC2   = r_inc2;
  assign STATE  = r_state;
  assign WINNER = r_winner;
  assign END    = r_end;
  assign MOVES  = r_moves;

endmodule
